arm_cntr_reconfig_ctrl: RTL and testbench

- Sequences run-time reconfiguration of NUM_CNTR PLL M-counter instances: modulus, initial_value and time_delay.
- Arbitrates round-robin between NUM_REQ requesters (software CSR path, calibration engine).
- For each change: holds the target counter in reset, loads new settings, releases reset, confirms cout toggles within a timeout, then responds.
- Sits between the PLL CSR block and the M-counter bank; it owns the counter configuration registers.

---
 rtl/arm_cntr_cfg_pkg.sv | 26 ++
 rtl/arm_rr_arbiter.sv | 43 ++++
 rtl/arm_cntr_reconfig_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_arm_cntr_reconfig_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_cntr_cfg_pkg.sv
// Shared types and constants for the PLL M-counter reconfiguration controller.
package arm_cntr_cfg_pkg;

    localparam int CFG_W = 32;
    localparam int SEL_W = 4;

    localparam int              DEF_MODULUS_VAL = 1;
    localparam logic [CFG_W-1:0] DEF_INIT        = 32'd1;
    localparam logic [CFG_W-1:0] DEF_DELAY       = 32'd0;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HOLD,
        LOAD,
        SETTLE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_BADPARAM = 2'b01,
        ST_TIMEOUT  = 2'b10
    } status_t;

endpackage

// File: rtl/arm_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the
// winner only when the caller says the grant was taken.
module arm_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/arm_cntr_reconfig_ctrl.sv
// Sequences reset / load / settle-check reconfiguration of a bank of PLL
// M-counters on behalf of several round-robin arbitrated requesters.
module arm_cntr_reconfig_ctrl
    import arm_cntr_cfg_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int NUM_CNTR     = 4,
    parameter int RST_CYCLES   = 4,
    parameter int SETTLE_EDGES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int DEF_MODULUS  = DEF_MODULUS_VAL
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ*CFG_W-1:0]  req_modulus,
    input  logic [NUM_REQ*CFG_W-1:0]  req_init,
    input  logic [NUM_REQ*CFG_W-1:0]  req_delay,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [1:0]                rsp_status,
    output logic                      busy,
    output logic [NUM_CNTR-1:0]       cntr_reset,
    output logic [NUM_CNTR*CFG_W-1:0] cntr_modulus,
    output logic [NUM_CNTR*CFG_W-1:0] cntr_init,
    output logic [NUM_CNTR*CFG_W-1:0] cntr_delay,
    input  logic [NUM_CNTR-1:0]       cntr_cout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CYC_W = $clog2(RST_CYCLES + 1) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    // LOAD is the final reset cycle, so HOLD covers the first RST_CYCLES-1.
    localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'((RST_CYCLES >= 2) ? RST_CYCLES - 2 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0]       EDGE_LAST = 4'(SETTLE_EDGES - 1);

    state_t                state_q, state_d;
    status_t               status_q;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx, win_q;
    logic                  accept, bad_param, load_en, trans, settle_ok, tmo_hit;
    logic [SEL_W-1:0]      sel_q;
    logic [CFG_W-1:0]      mod_q, init_q, delay_q;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [3:0]            edge_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [NUM_CNTR-1:0]   cout_s1, cout_s2, cout_prev, sel_mask;
    logic [CFG_W-1:0]      cfg_mod   [NUM_CNTR];
    logic [CFG_W-1:0]      cfg_init  [NUM_CNTR];
    logic [CFG_W-1:0]      cfg_delay [NUM_CNTR];

    assign accept    = (state_q == IDLE) && (|req_valid);
    assign bad_param = (mod_q == '0) ||
                       ({{(CFG_W-SEL_W){1'b0}}, sel_q} >= CFG_W'(NUM_CNTR));
    assign load_en   = (state_q == HOLD) && (state_d == LOAD);
    assign sel_mask  = NUM_CNTR'(1) << sel_q;
    assign settle_ok = trans && (edge_cnt == EDGE_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    arm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .idx     (grant_idx)
    );

    always_comb begin
        trans = 1'b0;
        for (int i = 0; i < NUM_CNTR; i++)
            if (sel_q == SEL_W'(i)) trans = cout_s2[i] ^ cout_prev[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = CAPTURE;
            CAPTURE: state_d = bad_param ? RESP : HOLD;
            HOLD:    if (cyc_cnt == HOLD_LAST) state_d = LOAD;
            LOAD:    state_d = SETTLE;
            SETTLE:  if (settle_ok || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_status = ST_OK;
        busy       = (state_q != IDLE);
        if (state_q == IDLE) req_ready = grant;
        if (state_q == RESP) begin
            rsp_valid  = NUM_REQ'(1) << win_q;
            rsp_status = status_q;
        end
    end

    // Control: synchronizers, sequencing counters, counter reset drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q      <= '0;
            status_q   <= ST_OK;
            cyc_cnt    <= '0;
            edge_cnt   <= '0;
            tmo_cnt    <= '0;
            cout_s1    <= '0;
            cout_s2    <= '0;
            cout_prev  <= '0;
            cntr_reset <= '1;
        end else begin
            cout_s1    <= cntr_cout;
            cout_s2    <= cout_s1;
            cout_prev  <= cout_s2;
            cntr_reset <= (state_d == HOLD || state_d == LOAD) ? sel_mask : '0;
            if (accept) win_q <= grant_idx;
            case (state_q)
                CAPTURE: begin
                    status_q <= bad_param ? ST_BADPARAM : ST_OK;
                    cyc_cnt  <= '0;
                end
                HOLD: cyc_cnt <= cyc_cnt + 1'b1;
                LOAD: begin
                    edge_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                SETTLE: begin
                    if (trans && edge_cnt != 4'hF) edge_cnt <= edge_cnt + 4'd1;
                    if (tmo_cnt != TMO_LAST)       tmo_cnt  <= tmo_cnt + 1'b1;
                    if (settle_ok)                 status_q <= ST_OK;
                    else if (tmo_hit)              status_q <= ST_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    // Request fields are pure data and need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && grant[i]) begin
                sel_q   <= req_sel[i*SEL_W +: SEL_W];
                mod_q   <= req_modulus[i*CFG_W +: CFG_W];
                init_q  <= req_init[i*CFG_W +: CFG_W];
                delay_q <= req_delay[i*CFG_W +: CFG_W];
            end
        end
    end

    // New settings appear at the start of LOAD while the counter is still in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                cfg_mod[i]   <= CFG_W'(DEF_MODULUS);
                cfg_init[i]  <= DEF_INIT;
                cfg_delay[i] <= DEF_DELAY;
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    cfg_mod[i]   <= mod_q;
                    cfg_init[i]  <= init_q;
                    cfg_delay[i] <= delay_q;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cfg_out
        assign cntr_modulus[g*CFG_W +: CFG_W] = cfg_mod[g];
        assign cntr_init[g*CFG_W +: CFG_W]    = cfg_init[g];
        assign cntr_delay[g*CFG_W +: CFG_W]   = cfg_delay[g];
    end

endmodule

// File: tb/tb_arm_cntr_reconfig_ctrl.sv
// Directed self-checking bench for arm_cntr_reconfig_ctrl (default parameters).
module tb_arm_cntr_reconfig_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [7:0]   req_sel = '0;
    logic [63:0]  req_modulus = '0;
    logic [63:0]  req_init = '0;
    logic [63:0]  req_delay = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_status;
    logic         busy;
    logic [3:0]   cntr_reset;
    logic [127:0] cntr_modulus;
    logic [127:0] cntr_init;
    logic [127:0] cntr_delay;
    logic [3:0]   cntr_cout = '0;
    bit           cout_run = 1'b0;

    int checks = 0;
    int errors = 0;

    arm_cntr_reconfig_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_modulus  (req_modulus),
        .req_init     (req_init),
        .req_delay    (req_delay),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .busy         (busy),
        .cntr_reset   (cntr_reset),
        .cntr_modulus (cntr_modulus),
        .cntr_init    (cntr_init),
        .cntr_delay   (cntr_delay),
        .cntr_cout    (cntr_cout)
    );

    always #5 clk = ~clk;

    // Counter bank model: every counter out of reset toggles cout, unrelated to clk.
    always begin
        #13;
        if (cout_run) cntr_cout = cntr_cout ^ ~cntr_reset;
    end

    task automatic set_req(input int r, input logic [3:0] sel, input logic [31:0] m,
                           input logic [31:0] i, input logic [31:0] d);
        req_sel[r*4 +: 4]       = sel;
        req_modulus[r*32 +: 32] = m;
        req_init[r*32 +: 32]    = i;
        req_delay[r*32 +: 32]   = d;
        req_valid[r]            = 1'b1;
    endtask

    // Returns one cycle after the accepting edge (cycle 1 of the transaction).
    task automatic wait_accept(input int r, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Latency is the cycle index of rsp_valid, counting the accept cycle as 0.
    task automatic wait_rsp(input int r, input int budget, output int lat,
                            output logic [1:0] st, output int rst_hi, output bit seen);
        seen = 1'b0; lat = 0; st = 2'b11; rst_hi = 0;
        for (int c = 1; c <= budget; c++) begin
            if (cntr_reset != 4'h0) rst_hi++;
            if (rsp_valid[r]) begin
                seen = 1'b1; lat = c; st = rsp_status;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cntr_reset !== 4'hF) begin errors++; $display("FAIL rst_cntr_reset: got %h expected f", cntr_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_status !== 2'b00) begin
            errors++; $display("FAIL rst_handshake: ready %b valid %b status %b expected all 0", req_ready, rsp_valid, rsp_status); end
        checks++; if (cntr_modulus !== {4{32'd1}}) begin errors++; $display("FAIL rst_modulus: got %h expected all 1", cntr_modulus); end
        checks++; if (cntr_init !== {4{32'd1}} || cntr_delay !== 128'd0) begin
            errors++; $display("FAIL rst_init_delay: init %h delay %h expected 1s and 0s", cntr_init, cntr_delay); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (cntr_reset !== 4'hF) begin errors++; $display("FAIL rst_hold_to_clk: got %h expected f", cntr_reset); end
        @(posedge clk);
        #1;
        checks++; if (cntr_reset !== 4'h0) begin errors++; $display("FAIL rst_release: got %h expected 0", cntr_reset); end
    endtask

    task automatic test_single_update();
        bit ok; int lat; int rh; logic [1:0] st; bit seen;
        cout_run = 1'b1;
        @(posedge clk); #1;
        set_req(0, 4'd2, 32'd5, 32'd1, 32'd0);
        wait_accept(0, ok);
        req_valid = 2'b00;
        checks++; if (!ok) begin errors++; $display("FAIL upd_accept: got no req_ready[0], expected accept"); end
        wait_rsp(0, 100, lat, st, rh, seen);
        checks++; if (!seen || st !== 2'b00) begin errors++; $display("FAIL upd_status: seen %0d status %b expected 1 00", seen, st); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL upd_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rh != 4) begin errors++; $display("FAIL upd_reset_len: got %0d cycles expected 4", rh); end
        checks++; if (lat < 8 || lat > 40) begin errors++; $display("FAIL upd_latency: got %0d expected 8..40", lat); end
        checks++; if (cntr_modulus !== {32'd1, 32'd5, 32'd1, 32'd1}) begin
            errors++; $display("FAIL upd_modulus: got %h expected counter 2 = 5, others 1", cntr_modulus); end
        @(posedge clk); #1;
        set_req(1, 4'd0, 32'd10, 32'd3, 32'd250);
        wait_accept(1, ok);
        req_valid = 2'b00;
        wait_rsp(1, 100, lat, st, rh, seen);
        checks++; if (!seen || st !== 2'b00 || rsp_valid !== 2'b10) begin
            errors++; $display("FAIL upd2_rsp: seen %0d status %b valid %b expected 1 00 10", seen, st, rsp_valid); end
        checks++; if (cntr_modulus !== {32'd1, 32'd5, 32'd1, 32'd10} || cntr_init !== {32'd1, 32'd1, 32'd1, 32'd3} ||
                      cntr_delay !== {32'd0, 32'd0, 32'd0, 32'd250}) begin
            errors++; $display("FAIL upd2_cfg: mod %h init %h delay %h expected counter 0 = 10/3/250", cntr_modulus, cntr_init, cntr_delay); end
    endtask

    task automatic test_bad_param();
        bit ok; int lat; int rh; logic [1:0] st; bit seen;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (k == 0) set_req(1, 4'd1, 32'd0, 32'd9, 32'd9);
            else        set_req(1, 4'd7, 32'd5, 32'd9, 32'd9);
            wait_accept(1, ok);
            req_valid = 2'b00;
            wait_rsp(1, 20, lat, st, rh, seen);
            checks++; if (!ok || !seen || lat != 2) begin
                errors++; $display("FAIL bad%0d_latency: accept %0d seen %0d lat %0d expected 1 1 2", k, ok, seen, lat); end
            checks++; if (st !== 2'b01 || rsp_valid !== 2'b10) begin
                errors++; $display("FAIL bad%0d_status: status %b valid %b expected 01 10", k, st, rsp_valid); end
            checks++; if (rh != 0) begin errors++; $display("FAIL bad%0d_no_reset: got %0d reset cycles expected 0", k, rh); end
        end
        checks++; if (cntr_modulus !== {32'd1, 32'd5, 32'd1, 32'd10}) begin
            errors++; $display("FAIL bad_cfg_kept: got %h expected unchanged", cntr_modulus); end
    endtask

    task automatic test_arbitration();
        int lat; int rh; logic [1:0] st; bit seen; bit ok; logic [1:0] g; logic [1:0] exp_g;
        @(posedge clk); #1;
        set_req(0, 4'd0, 32'd6, 32'd2, 32'd11);
        set_req(1, 4'd3, 32'd4, 32'd5, 32'd22);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0; g = 2'b00;
            for (int c = 0; c < 200; c++) begin
                #1;
                if (req_ready != 2'b00) begin ok = 1'b1; g = req_ready; break; end
                @(negedge clk);
            end
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (!ok || g !== exp_g) begin
                errors++; $display("FAIL arb_grant%0d: got %b expected %b", k, g, exp_g); end
            @(posedge clk); #1;
            wait_rsp((k % 2), 100, lat, st, rh, seen);
            checks++; if (!seen || st !== 2'b00) begin
                errors++; $display("FAIL arb_rsp%0d: seen %0d status %b expected 1 00", k, seen, st); end
        end
        req_valid = 2'b00;
        checks++; if (cntr_modulus !== {32'd4, 32'd5, 32'd1, 32'd6}) begin
            errors++; $display("FAIL arb_cfg: got %h expected counters 0 = 6, 3 = 4", cntr_modulus); end
    endtask

    task automatic test_timeout();
        bit ok; int lat; int rh; logic [1:0] st; bit seen;
        cout_run = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        set_req(0, 4'd1, 32'd3, 32'd7, 32'd100);
        wait_accept(0, ok);
        req_valid = 2'b00;
        wait_rsp(0, 1200, lat, st, rh, seen);
        checks++; if (!seen || lat != 1030) begin
            errors++; $display("FAIL tmo_latency: seen %0d lat %0d expected 1 1030", seen, lat); end
        checks++; if (st !== 2'b10) begin errors++; $display("FAIL tmo_status: got %b expected 10", st); end
        @(posedge clk); #1;
        checks++; if (cntr_reset !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_after: reset %h busy %b expected 0 0", cntr_reset, busy); end
        checks++; if (cntr_modulus[32 +: 32] !== 32'd3 || cntr_init[32 +: 32] !== 32'd7 || cntr_delay[32 +: 32] !== 32'd100) begin
            errors++; $display("FAIL tmo_cfg_kept: mod %0d init %0d delay %0d expected 3 7 100",
                               cntr_modulus[32 +: 32], cntr_init[32 +: 32], cntr_delay[32 +: 32]); end
        cout_run = 1'b1;
    endtask

    task automatic test_reset_mid_hold();
        bit ok; int lat; int rh; logic [1:0] st; bit seen; bit stray;
        @(posedge clk); #1;
        set_req(0, 4'd3, 32'd9, 32'd4, 32'd33);
        wait_accept(0, ok);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (cntr_reset !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_in_hold: reset %b busy %b expected 1000 1", cntr_reset, busy); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (cntr_reset !== 4'hF || busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_status !== 2'b00) begin
            errors++; $display("FAIL mid_outputs: reset %h busy %b valid %b status %b expected f 0 00 00",
                               cntr_reset, busy, rsp_valid, rsp_status); end
        checks++; if (cntr_modulus !== {4{32'd1}} || cntr_init !== {4{32'd1}} || cntr_delay !== 128'd0) begin
            errors++; $display("FAIL mid_cfg_default: mod %h expected all 1", cntr_modulus); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (rsp_valid != 2'b00) stray = 1'b1;
        end
        checks++; if (stray || cntr_reset !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_no_rsp: stray %0d reset %h busy %b expected 0 0 0", stray, cntr_reset, busy); end
        set_req(1, 4'd3, 32'd9, 32'd4, 32'd33);
        wait_accept(1, ok);
        req_valid = 2'b00;
        wait_rsp(1, 100, lat, st, rh, seen);
        checks++; if (!ok || !seen || st !== 2'b00 || rh != 4) begin
            errors++; $display("FAIL mid_retry: accept %0d seen %0d status %b reset cycles %0d expected 1 1 00 4", ok, seen, st, rh); end
        checks++; if (cntr_modulus !== {32'd9, 32'd1, 32'd1, 32'd1} || cntr_delay[96 +: 32] !== 32'd33) begin
            errors++; $display("FAIL mid_retry_cfg: mod %h expected counter 3 = 9", cntr_modulus); end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_bad_param();
        test_arbitration();
        test_timeout();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
